// File: rtl/regfile_pkg.sv
// regfile_pkg: shared regfile constants and width helpers (address width, busy-count width)
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  function automatic int aw(input int n);
    return $clog2(n);
  endfunction
  function automatic int cw(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bit per register (flush > issue > write-clear) plus registered popcount; ports clk, rst_n, wr_en/wr_addr, iss_en/iss_rd, flush -> busy, busy_cnt
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR = 2,
  parameter int ZERO_R0 = 0,
  localparam int AW = aw(NREGS),
  localparam int CW = cw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    busy,
  output logic [CW-1:0]       busy_cnt
);
  logic [NREGS-1:0] nb;
  logic [CW-1:0] cnt;
  always_comb begin
    nb = busy;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j]) nb[wr_addr[j*AW +: AW]] = 1'b0;
    if (iss_en) nb[iss_rd] = 1'b1;
    if (flush) nb = '0;
    if (ZERO_R0 != 0) nb[0] = 1'b0;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + CW'(nb[i]);
  end
  always_ff @(posedge clk) begin
    busy <= rst_n ? nb : '0;
    busy_cnt <= rst_n ? cnt : '0;
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port regfile with priority writes, optional bypass/zero-r0 and busy scoreboard; ports clk, rst_n, rd_addr -> rd_data/rd_busy, wr_en/wr_addr/wr_data, iss_en/iss_rd, flush -> busy_cnt
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 3,
  parameter int NWR = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS = 1,
  localparam int AW = aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy;
  rf_scoreboard #(.NREGS(NREGS), .NWR(NWR), .ZERO_R0(ZERO_R0)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .iss_en(iss_en),
    .iss_rd(iss_rd),
    .flush(flush),
    .busy(busy),
    .busy_cnt(busy_cnt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && !(ZERO_R0 != 0 && wr_addr[j*AW +: AW] == '0))
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    logic b;
    always_comb begin
      a = rd_addr[k*AW +: AW];
      d = mem[a];
      b = busy[a];
      if (BYPASS != 0)
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
            d = wr_data[j*XLEN +: XLEN];
            b = 1'b0;
          end
      if (!rst_n || (ZERO_R0 != 0 && a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end
    assign rd_data[k*XLEN +: XLEN] = d;
    assign rd_busy[k] = b;
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench driving a bypass/FP-style and a no-bypass/zero-r0 regfile in parallel
module tb_regfile_mp_sb;
  localparam int AW = 5;
  localparam int XL = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic [3*AW-1:0] rd_addr;
  logic [2-1:0] wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XL-1:0] wr_data;
  logic iss_en, flush;
  logic [AW-1:0] iss_rd;
  logic [3*XL-1:0] a_rd, b_rd;
  logic [2:0] a_busy, b_busy;
  logic [AW:0] a_cnt, b_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  regfile_mp_sb #(.ZERO_R0(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd), .rd_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .busy_cnt(a_cnt)
  );
  regfile_mp_sb #(.ZERO_R0(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd), .rd_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .busy_cnt(b_cnt)
  );
  function automatic logic [31:0] obs(input int s);
    case (s)
      0: return a_rd[0 +: XL];
      1: return 32'(a_busy[0]);
      2: return 32'(a_cnt);
      3: return b_rd[0 +: XL];
      4: return 32'(b_busy[0]);
      5: return 32'(b_cnt);
      6: return 32'(a_busy[1]);
      7: return a_rd[2*XL +: XL];
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic want(input string tag, input int sel, input logic [31:0] exp);
    q.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XL +: XL] = d;
  endtask
  task automatic idle();
    wr_en = '0;
    iss_en = 1'b0;
    flush = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_rd = '0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    rd_addr[0 +: AW] = 5'd5;
    want("rst_data", 0, 0);
    want("rst_busy", 1, 0);
    want("rst_cnt", 2, 0);
    want("rst_cnt_b", 5, 0);
    drain();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    want("r5_written", 0, 32'hDEAD_BEEF);
    drain();
    rst_n = 1'b0;
    want("r5_in_reset", 0, 0);
    drain();
    step();
    rst_n = 1'b1;
    want("r5_after_rst", 0, 0);
    want("r5_after_rst_b", 3, 0);
    want("cnt_after_rst", 2, 0);
    drain();
    rd_addr[0 +: AW] = 5'd3;
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    want("bypass_prio", 0, 32'h22);
    want("nobypass_old", 3, 0);
    drain();
    step();
    idle();
    want("prio_stored", 0, 32'h22);
    want("prio_stored_b", 3, 32'h22);
    drain();
    rd_addr[0 +: AW] = 5'd7;
    iss_en = 1'b1;
    iss_rd = 5'd7;
    step();
    idle();
    want("iss_busy", 1, 1);
    want("iss_cnt", 2, 1);
    want("iss_busy_b", 4, 1);
    want("iss_cnt_b", 5, 1);
    drain();
    wr(0, 5'd7, 32'h77);
    want("wr_bypass_busy", 1, 0);
    want("wr_nobypass_busy", 4, 1);
    drain();
    step();
    idle();
    want("wr_clears", 1, 0);
    want("wr_clears_cnt", 2, 0);
    want("wr_clears_cnt_b", 5, 0);
    drain();
    iss_en = 1'b1;
    iss_rd = 5'd7;
    step();
    iss_en = 1'b1;
    iss_rd = 5'd7;
    wr(0, 5'd7, 32'h99);
    step();
    idle();
    want("iss_wins_busy", 1, 1);
    want("iss_wins_cnt", 2, 1);
    want("iss_wins_data", 0, 32'h99);
    want("iss_wins_data_b", 3, 32'h99);
    want("iss_wins_cnt_b", 5, 1);
    drain();
    for (int i = 0; i < 3; i++) begin
      iss_en = 1'b1;
      iss_rd = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
      step();
    end
    idle();
    want("cnt_four", 2, 4);
    want("cnt_four_b", 5, 4);
    drain();
    flush = 1'b1;
    iss_en = 1'b1;
    iss_rd = 5'd9;
    step();
    idle();
    rd_addr[0 +: AW] = 5'd9;
    rd_addr[AW +: AW] = 5'd1;
    want("flush_r9", 1, 0);
    want("flush_r1", 6, 0);
    want("flush_cnt", 2, 0);
    want("flush_cnt_b", 5, 0);
    drain();
    rd_addr[0 +: AW] = 5'd0;
    rd_addr[2*AW +: AW] = 5'd3;
    wr(1, 5'd0, 32'h5);
    iss_en = 1'b1;
    iss_rd = 5'd0;
    step();
    idle();
    want("r0_fp_data", 0, 32'h5);
    want("r0_fp_busy", 1, 1);
    want("r0_fp_cnt", 2, 1);
    want("r0_int_data", 3, 0);
    want("r0_int_busy", 4, 0);
    want("r0_int_cnt", 5, 0);
    want("port2_read", 7, 32'h22);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
